dp_mem_responder: RTL

Memory-side responder for the datapath cache interface. It answers instruction fetches (`imemREN`) and data loads, stores and atomics (`dmemREN`, `dmemWEN`, `datomic`) from a local word-addressed RAM with a fixed, parameterised wait-state latency. It returns `ihit`/`dhit` handshakes and read data, and implements the LL/SC link register. It is used as the memory end for single-core pipeline benches and as the fixed-latency stand-in for the cache in system bring-up.

---
 rtl/dp_mem_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dp_mem_responder.sv
// dp_mem_responder
// Fixed-latency memory responder for the datapath cache interface. Serves
// instruction fetches and data loads/stores/atomics from a local
// word-addressed RAM, returning one-cycle ihit/dhit pulses after LAT wait
// cycles. Implements the LL/SC link register.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   halt                blocks acceptance of new requests
//   imemREN, imemaddr   instruction read request / byte address
//   dmemREN, dmemWEN    data read / write request (both high = write)
//   datomic             marks data request as LL (read) or SC (write)
//   dmemaddr, dmemstore data byte address / store data
//   ihit, imemload      instruction completion pulse / fetched word
//   dhit, dmemload      data completion pulse / load data or SC result
//
// state | meaning
// IDLE  | waiting; data requests take priority over instruction requests
// DBUSY | counting wait cycles for an accepted data request
// IBUSY | counting wait cycles for an accepted instruction request

module dp_mem_responder #(
    parameter int WORDS = 1024,
    parameter int LAT   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload
);

    localparam int AW = $clog2(WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic            link_valid;
    logic [AW-1:0]   link_addr;
    logic [31:0]     mem [0:WORDS-1];

    logic [AW-1:0]   iidx, didx;
    logic            d_req;
    logic            link_match;
    logic            sc_ok;
    logic            mem_we;

    // Byte offset and upper address bits are deliberately ignored so that
    // addresses wrap modulo the RAM size.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[31:AW+2], imemaddr[1:0],
                                dmemaddr[31:AW+2], dmemaddr[1:0]};

    assign iidx       = imemaddr[AW+1:2];
    assign didx       = dmemaddr[AW+1:2];
    assign d_req      = dmemREN | dmemWEN;
    assign link_match = link_valid && (link_addr == didx);
    assign sc_ok      = datomic && link_match;
    // Write on the hit edge: plain stores always, SC only when the link holds.
    assign mem_we     = dhit && dmemWEN && (!datomic || link_match);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Requests are not latched at accept; dropping the request while busy
    // abandons it without a hit or a write.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ihit      = 1'b0;
        dhit      = 1'b0;
        case (state)
            IDLE: begin
                if (!halt && d_req) begin
                    state_nxt = DBUSY;
                    cnt_nxt   = LAT_M1;
                end else if (!halt && imemREN) begin
                    state_nxt = IBUSY;
                    cnt_nxt   = LAT_M1;
                end
            end
            DBUSY: begin
                if (!d_req) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    dhit      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            IBUSY: begin
                if (!imemREN) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    ihit      = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imemload = 32'd0;
        dmemload = 32'd0;
        if (ihit) begin
            imemload = mem[iidx];
        end
        if (dhit) begin
            if (dmemWEN) begin
                dmemload = {31'd0, sc_ok};
            end else begin
                dmemload = mem[didx];
            end
        end
    end

    // RAM has no reset; an asserted RST forces IDLE, so mem_we is low and
    // any pending write is dropped.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[didx] <= dmemstore;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (dhit) begin
            if (dmemWEN) begin
                // SC always consumes the link; a plain store only breaks it
                // when it hits the linked word.
                if (datomic || link_match) begin
                    link_valid <= 1'b0;
                end
            end else if (datomic) begin
                link_valid <= 1'b1;
                link_addr  <= didx;
            end
        end
    end

endmodule
